// File: rtl/line_reorder_pkg.sv
// Shared constants and helpers for the ping-pong line reorder stage.
package line_reorder_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_MIRROR = 2'd1;
  localparam logic [1:0] MODE_LSWAP  = 2'd2;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_state_t;

  // Source lane feeding output lane 'lane' when lanes are reversed.
  function automatic int rev_lane(input int lane, input int lanes);
    return lanes - 1 - lane;
  endfunction

endpackage

// File: rtl/line_reorder_ram.sv
// Simple dual-port line RAM with registered read; the bank index is the address MSB.
module line_reorder_ram
  import line_reorder_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Each bank spans 2**(ADDR_W-1) words so the MSB can select the bank directly.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_reorder_pp.sv
// Ping-pong line buffer: fills one bank while draining the other in pass, mirror or lane-swap order.
module line_reorder_pp
  import line_reorder_pkg::*;
#(
  parameter  int LANES  = 2,
  parameter  int LANE_W = 64,
  parameter  int WORDS  = 48,
  localparam int AW     = $clog2(WORDS),
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_len,
  input  logic              err_clr,
  output logic              busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

  bank_state_t   bank_st     [2];
  bank_state_t   bank_st_nxt [2];
  logic [AW-1:0] bank_last   [2];
  logic [1:0]    bank_mode   [2];
  logic          wr_sel, rd_sel;
  logic [AW-1:0] wr_cnt, rd_j;
  logic          wr_acc, wr_at_end, wr_close, err_set;

  logic          rd_active, rd_mirror, rd_last_p0, issue_p0;
  logic [AW-1:0] rd_addr_p0;
  logic [1:0]    occ_p0;

  logic              vld_p1, last_p1, rev_p1;
  logic [DATA_W-1:0] ram_data_p1, rev_data_p1, map_data_p1;

  logic [1:0]        sk_cnt_p2;
  logic [DATA_W-1:0] sk_d0_p2, sk_d1_p2;
  logic              sk_l0_p2, sk_l1_p2;
  logic              pop_p2;

  assign in_ready  = (bank_st[wr_sel] == BANK_EMPTY) || (bank_st[wr_sel] == BANK_FILL);
  assign wr_acc    = in_valid && in_ready;
  assign wr_at_end = (wr_cnt == LAST_IDX);
  assign wr_close  = wr_acc && (in_last || wr_at_end);
  // Closing by in_last exactly at the final slot is the only well-formed line.
  assign err_set   = wr_close && (in_last != wr_at_end);

  // ---- stage p0: read address issue ----
  assign pop_p2     = out_valid && out_ready;
  assign rd_active  = (bank_st[rd_sel] == BANK_FULL) || (bank_st[rd_sel] == BANK_DRAIN);
  assign rd_mirror  = (bank_mode[rd_sel] == MODE_MIRROR);
  assign rd_last_p0 = (rd_j == bank_last[rd_sel]);
  assign rd_addr_p0 = rd_mirror ? (bank_last[rd_sel] - rd_j) : rd_j;
  assign occ_p0     = sk_cnt_p2 + {1'b0, vld_p1};
  // The beat leaving this cycle frees its slot, which keeps a steady stream at one beat per cycle.
  assign issue_p0   = rd_active && ((occ_p0 < 2'd2) || ((occ_p0 == 2'd2) && pop_p2));

  always_comb begin
    for (int b = 0; b < 2; b++) bank_st_nxt[b] = bank_st[b];
    if (wr_acc) bank_st_nxt[wr_sel] = wr_close ? BANK_FULL : BANK_FILL;
    if (rd_active) bank_st_nxt[rd_sel] = (issue_p0 && rd_last_p0) ? BANK_EMPTY : BANK_DRAIN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_st[b]   <= BANK_EMPTY;
        bank_last[b] <= '0;
        bank_mode[b] <= MODE_PASS;
      end
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      wr_cnt  <= '0;
      rd_j    <= '0;
      err_len <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) bank_st[b] <= bank_st_nxt[b];
      if (wr_acc) begin
        if (bank_st[wr_sel] == BANK_EMPTY) bank_mode[wr_sel] <= cfg_mode;
        if (wr_close) begin
          bank_last[wr_sel] <= wr_cnt;
          wr_sel            <= ~wr_sel;
          wr_cnt            <= '0;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
      if (issue_p0) begin
        if (rd_last_p0) begin
          rd_j   <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          rd_j <= rd_j + AW'(1);
        end
      end
      if (err_set)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;
    end
  end

  line_reorder_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(AW + 1)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr({wr_sel, wr_cnt}),
    .wdata(in_data),
    .re   (issue_p0),
    .raddr({rd_sel, rd_addr_p0}),
    .rdata(ram_data_p1)
  );

  // ---- stage p1: RAM data and lane reorder ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      rev_p1  <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      if (issue_p0) begin
        last_p1 <= rd_last_p0;
        rev_p1  <= (bank_mode[rd_sel] == MODE_MIRROR) || (bank_mode[rd_sel] == MODE_LSWAP);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_rev
    assign rev_data_p1[l*LANE_W +: LANE_W] = ram_data_p1[rev_lane(l, LANES)*LANE_W +: LANE_W];
  end

  assign map_data_p1 = rev_p1 ? rev_data_p1 : ram_data_p1;

  // ---- stage p2: two-entry output skid buffer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_cnt_p2 <= 2'd0;
      sk_d0_p2  <= '0;
      sk_d1_p2  <= '0;
      sk_l0_p2  <= 1'b0;
      sk_l1_p2  <= 1'b0;
    end else begin
      case ({vld_p1, pop_p2})
        2'b10: begin
          if (sk_cnt_p2 == 2'd0) begin
            sk_d0_p2 <= map_data_p1;
            sk_l0_p2 <= last_p1;
          end else begin
            sk_d1_p2 <= map_data_p1;
            sk_l1_p2 <= last_p1;
          end
          sk_cnt_p2 <= sk_cnt_p2 + 2'd1;
        end
        2'b01: begin
          sk_d0_p2  <= sk_d1_p2;
          sk_l0_p2  <= sk_l1_p2;
          sk_cnt_p2 <= sk_cnt_p2 - 2'd1;
        end
        2'b11: begin
          if (sk_cnt_p2 == 2'd1) begin
            sk_d0_p2 <= map_data_p1;
            sk_l0_p2 <= last_p1;
          end else begin
            sk_d0_p2 <= sk_d1_p2;
            sk_l0_p2 <= sk_l1_p2;
            sk_d1_p2 <= map_data_p1;
            sk_l1_p2 <= last_p1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (sk_cnt_p2 != 2'd0);
  assign out_data  = sk_d0_p2;
  assign out_last  = sk_l0_p2;
  assign busy      = (bank_st[0] != BANK_EMPTY) || (bank_st[1] != BANK_EMPTY) ||
                     vld_p1 || (sk_cnt_p2 != 2'd0);

endmodule

// File: tb/tb_line_reorder_pp.sv
// Directed bench for line_reorder_pp: pass/mirror/lane-swap ordering, length errors, backpressure, reset.
module tb_line_reorder_pp;
  import line_reorder_pkg::*;

  localparam int LANES  = 2;
  localparam int LANE_W = 64;
  localparam int WORDS  = 48;
  localparam int DW     = LANES * LANE_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg_mode = MODE_PASS;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          err_len;
  logic          err_clr = 1'b0;
  logic          busy;

  logic [DW-1:0] in_q_d [$];
  bit            in_q_l [$];
  logic [1:0]    in_q_m [$];
  logic [DW-1:0] exp_d  [$];
  bit            exp_l  [$];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int first_vld_cyc = -1;
  int stalls = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_reorder_pp #(.LANES(LANES), .LANE_W(LANE_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_len(err_len), .err_clr(err_clr), .busy(busy)
  );

  function automatic logic [DW-1:0] mkw(input int hi, input int lo);
    return {64'(hi), 64'(lo)};
  endfunction

  task automatic load_line(input int n, input logic [1:0] mode, input int last_at,
                           input int hi_base, input int lo_base, input bit hi_zero);
    for (int k = 0; k < n; k++) begin
      in_q_d.push_back(hi_zero ? mkw(0, lo_base + k) : mkw(hi_base + k, lo_base + k));
      in_q_l.push_back(k == last_at);
      in_q_m.push_back(mode);
    end
  endtask

  task automatic producer(input int budget, input int stop_after);
    int sent = 0;
    int n = 0;
    while (in_q_d.size() > 0 && sent < stop_after && n < budget) begin
      in_valid = 1'b1;
      in_data  = in_q_d[0];
      in_last  = in_q_l[0];
      cfg_mode = in_q_m[0];
      if (in_ready) begin
        if (in_q_l[0]) last_acc_cyc = cyc;
        void'(in_q_d.pop_front());
        void'(in_q_l.pop_front());
        void'(in_q_m.pop_front());
        sent++;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests_run++;
    if (n >= budget) begin
      tests_failed++;
      $display("FAIL producer_timeout: sent %0d beats, required %0d more", sent, in_q_d.size());
    end
  endtask

  task automatic consumer(input int nbeats, input bit toggle, input int budget, input string tag);
    int got = 0;
    int n = 0;
    logic [DW-1:0] ed;
    bit el;
    first_vld_cyc = -1;
    while (got < nbeats && n < budget) begin
      out_ready = toggle ? (n % 2 == 0) : 1'b1;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_valid && out_ready) begin
        ed = exp_d.pop_front();
        el = exp_l.pop_front();
        tests_run++;
        if (out_data !== ed || out_last !== el) begin
          tests_failed++;
          $display("FAIL %s beat %0d: got data=%h last=%0b, required data=%h last=%0b",
                   tag, got, out_data, out_last, ed, el);
        end
        got++;
      end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    tests_run++;
    if (got < nbeats) begin
      tests_failed++;
      $display("FAIL %s_timeout: got %0d beats, required %0d", tag, got, nbeats);
    end
  endtask

  task automatic idle_check(input string tag);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_idle: got out_valid=%0b busy=%0b in_ready=%0b, required 0 0 1",
               tag, out_valid, busy, in_ready);
    end
  endtask

  task automatic check_err(input string tag, input logic want);
    tests_run++;
    if (err_len !== want) begin
      tests_failed++;
      $display("FAIL %s_err_len: got %0b, required %0b", tag, err_len, want);
    end
  endtask

  task automatic clear_err;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run += 6;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %0b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
    if (out_data !== '0) begin tests_failed++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    if (out_last !== 1'b0) begin tests_failed++; $display("FAIL rst_out_last: got %0b, required 0", out_last); end
    if (err_len !== 1'b0) begin tests_failed++; $display("FAIL rst_err_len: got %0b, required 0", err_len); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    idle_check("post_reset");
  endtask

  task automatic test_pass;
    stalls = 0;
    load_line(WORDS, MODE_PASS, WORDS - 1, 0, 0, 1'b1);
    for (int j = 0; j < WORDS; j++) begin
      exp_d.push_back(DW'(j));
      exp_l.push_back(j == WORDS - 1);
    end
    fork
      producer(200, 1000);
      consumer(WORDS, 1'b0, 200, "pass");
    join
    tests_run++;
    if (first_vld_cyc - last_acc_cyc != 3) begin
      tests_failed++;
      $display("FAIL pass_latency: got %0d cycles, required 3", first_vld_cyc - last_acc_cyc);
    end
    tests_run++;
    if (stalls != 0) begin
      tests_failed++;
      $display("FAIL pass_stalls: got %0d in_ready stalls, required 0", stalls);
    end
    check_err("pass", 1'b0);
    idle_check("pass");
  endtask

  task automatic test_mirror;
    load_line(WORDS, MODE_MIRROR, WORDS - 1, 100, 0, 1'b0);
    for (int j = 0; j < WORDS; j++) begin
      exp_d.push_back(mkw(47 - j, 147 - j));
      exp_l.push_back(j == WORDS - 1);
    end
    fork
      producer(200, 1000);
      consumer(WORDS, 1'b0, 200, "mirror");
    join
    check_err("mirror", 1'b0);
    idle_check("mirror");
  endtask

  task automatic test_back_to_back;
    stalls = 0;
    for (int l = 0; l < 4; l++) begin
      load_line(WORDS, (l % 2 == 0) ? MODE_PASS : MODE_LSWAP, WORDS - 1, l * 1000 + 500, l * 1000, 1'b0);
      for (int j = 0; j < WORDS; j++) begin
        exp_d.push_back((l % 2 == 0) ? mkw(l * 1000 + 500 + j, l * 1000 + j)
                                     : mkw(l * 1000 + j, l * 1000 + 500 + j));
        exp_l.push_back(j == WORDS - 1);
      end
    end
    fork
      producer(2000, 1000);
      consumer(4 * WORDS, 1'b1, 2000, "b2b");
    join
    tests_run++;
    if (stalls == 0) begin
      tests_failed++;
      $display("FAIL b2b_backpressure: got %0d in_ready stalls, required > 0", stalls);
    end
    check_err("b2b", 1'b0);
    idle_check("b2b");
  endtask

  task automatic test_short_line;
    load_line(10, MODE_MIRROR, 9, 100, 0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      exp_d.push_back(mkw(9 - j, 109 - j));
      exp_l.push_back(j == 9);
    end
    fork
      producer(200, 1000);
      consumer(10, 1'b0, 200, "short");
    join
    check_err("short", 1'b1);
    clear_err();
    check_err("short_clr", 1'b0);
    idle_check("short");
  endtask

  task automatic test_long_line;
    load_line(50, MODE_PASS, 49, 0, 200, 1'b1);
    for (int j = 0; j < WORDS; j++) begin
      exp_d.push_back(mkw(0, 200 + j));
      exp_l.push_back(j == WORDS - 1);
    end
    exp_d.push_back(mkw(0, 248)); exp_l.push_back(1'b0);
    exp_d.push_back(mkw(0, 249)); exp_l.push_back(1'b1);
    fork
      producer(300, 1000);
      consumer(50, 1'b0, 300, "long");
    join
    check_err("long", 1'b1);
    clear_err();
    check_err("long_clr", 1'b0);
    idle_check("long");
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    load_line(WORDS, MODE_PASS, WORDS - 1, 0, 3000, 1'b1);
    load_line(30, MODE_PASS, -1, 0, 4000, 1'b1);
    out_ready = 1'b1;
    producer(400, WORDS + 20);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_draining: got out_valid=%0b before reset, required 1", out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run += 2;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_out_valid: got %0b, required 0", out_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %0b, required 0", busy); end
    in_q_d.delete(); in_q_l.delete(); in_q_m.delete();
    exp_d.delete(); exp_l.delete();
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL rmid_quiet: got %0d valid cycles after reset, required 0", seen);
    end
    load_line(WORDS, MODE_PASS, WORDS - 1, 0, 7000, 1'b1);
    for (int j = 0; j < WORDS; j++) begin
      exp_d.push_back(mkw(0, 7000 + j));
      exp_l.push_back(j == WORDS - 1);
    end
    fork
      producer(200, 1000);
      consumer(WORDS, 1'b0, 200, "rmid_new");
    join
    check_err("rmid", 1'b0);
    idle_check("rmid");
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mirror();
    test_back_to_back();
    test_short_line();
    test_long_line();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
